// File: rtl/ysyx_22050058_dmem_resp.sv
// Single-outstanding data-memory responder: stores commit at accept, loads are
// captured entering RESP after a programmable wait, and responses are held until taken.
module ysyx_22050058_dmem_resp #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LAT        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] acc_cnt
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               err_q, err_d;
  logic [63:0]        rdata_q, rdata_d;
  logic               rerr_q, rerr_d;
  logic [31:0]        acc_q, acc_d;

  logic [63:0]        mem [DEPTH];

  logic               accept_c;
  logic [IDX_W-1:0]   req_idx_c;
  logic               req_err_c;
  logic               unused_addr_lsb_c;

  // Byte offset within the word carries no meaning for a 64-bit word memory.
  assign unused_addr_lsb_c = ^req_addr[2:0];

  assign req_idx_c  = req_addr[DEPTH_LOG2+2:3];
  assign req_err_c  = |req_addr[63:DEPTH_LOG2+3];
  assign req_ready  = (state_q == IDLE) && !rst;
  assign accept_c   = req_valid && req_ready;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = rerr_q;
  assign acc_cnt    = acc_q;

  // Next-state and response capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          we_d  = req_we;
          idx_d = req_idx_c;
          err_d = req_err_c;
          if (LAT == 0) begin
            state_d = RESP;
            rdata_d = (req_err_c || req_we) ? 64'd0 : mem[req_idx_c];
            rerr_d  = req_err_c;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_W'(LAT);
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          rdata_d = (err_q || we_q) ? 64'd0 : mem[idx_q];
          rerr_d  = err_q;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          acc_d   = acc_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= 64'd0;
      rerr_q  <= 1'b0;
      acc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
      acc_q   <= acc_d;
    end
  end

  // Array is never reset; stores land at the accept edge, byte-masked.
  always_ff @(posedge clk) begin
    if (accept_c && req_we && !req_err_c) begin
      for (int b = 0; b < 8; b++) begin
        if (req_wmask[b]) mem[req_idx_c][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050058_dmem_resp.sv
// Scoreboard bench for the dmem responder: LAT=2 instance under a monitor,
// plus a LAT=0 instance checked cycle by cycle for back-to-back behaviour.
module tb_ysyx_22050058_dmem_resp;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic [31:0] acc_cnt;

  logic        f_valid, f_ready, f_we, f_resp_valid, f_err;
  logic [63:0] f_addr, f_wdata, f_rdata;
  logic [7:0]  f_wmask;
  logic [31:0] f_acc_cnt;

  always #5 clk = ~clk;

  ysyx_22050058_dmem_resp #(.DEPTH_LOG2(8), .LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .acc_cnt(acc_cnt)
  );

  ysyx_22050058_dmem_resp #(.DEPTH_LOG2(8), .LAT(0)) u_fast (
    .clk(clk), .rst(rst),
    .req_valid(f_valid), .req_ready(f_ready), .req_we(f_we),
    .req_addr(f_addr), .req_wdata(f_wdata), .req_wmask(f_wmask),
    .resp_valid(f_resp_valid), .resp_ready(1'b1),
    .resp_rdata(f_rdata), .resp_err(f_err), .acc_cnt(f_acc_cnt)
  );

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_exp = 0;
  logic prev_rv = 1'b0;

  localparam logic [63:0] W1  = 64'h1122334455667788;
  localparam logic [63:0] WM  = 64'hFFFFFFFF00000000;
  localparam logic [63:0] WD  = 64'hDEADBEEFCAFEF00D;
  localparam logic [63:0] WT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] WF  = 64'h0F1E2D3C4B5A6978;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: latency on rise, held payload every RESP cycle, pop on handshake.
  always @(negedge clk) begin
    if (resp_valid && !rst) begin
      if (sb.size() == 0) begin
        chk("resp_unexpected", 64'(resp_valid), 64'd0);
      end else begin
        if (!prev_rv) chk("latency", 64'(cyc - sb[0].acc_cyc), 64'(LAT + 1));
        chk("rdata", resp_rdata, sb[0].rdata);
        chk("err", 64'(resp_err), 64'(sb[0].err));
        chk("req_ready_in_resp", 64'(req_ready), 64'd0);
        if (resp_ready) void'(sb.pop_front());
      end
    end
    prev_rv = resp_valid;
  end

  task automatic drive_point();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [7:0] wmask, input logic [63:0] exp_rd, input logic exp_err);
    exp_t e;
    int   n = 0;
    req_we = we; req_addr = addr; req_wdata = wdata; req_wmask = wmask; req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) begin
      chk("accept_timeout", 64'(req_ready), 64'd1);
    end else begin
      e.rdata = exp_rd; e.err = exp_err; e.acc_cyc = cyc;
      sb.push_back(e);
      n_exp++;
    end
    drive_point();
    // Scramble the request bus while busy; it must have no effect.
    req_valid = 1'b0;
    req_we    = 1'b1;
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    req_wmask = 8'hFF;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || resp_valid) && n < 60) begin
      n++;
      @(negedge clk);
    end
    chk("drain", 64'(sb.size()), 64'd0);
    chk("acc_cnt", 64'(acc_cnt), 64'(n_exp));
    drive_point();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_wmask = '0; resp_ready = 1'b1;
    f_valid = 1'b0; f_we = 1'b0; f_addr = '0; f_wdata = '0; f_wmask = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_err", 64'(resp_err), 64'd0);
    chk("rst_acc_cnt", 64'(acc_cnt), 64'd0);
    drive_point();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);
    drive_point();

    // Store then load back.
    issue(1'b1, 64'h10, W1, 8'hFF, 64'd0, 1'b0);
    issue(1'b0, 64'h10, 64'd0, 8'h00, W1, 1'b0);
    wait_done();

    // Byte mask: clear lower four lanes through an unaligned address.
    issue(1'b1, 64'h10, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'd0, 1'b0);
    issue(1'b1, 64'h14, 64'd0, 8'h0F, 64'd0, 1'b0);
    issue(1'b0, 64'h10, 64'd0, 8'h00, WM, 1'b0);
    issue(1'b1, 64'h10, 64'd0, 8'h00, 64'd0, 1'b0);
    issue(1'b0, 64'h13, 64'd0, 8'h00, WM, 1'b0);
    wait_done();

    // Out-of-range requests and the last in-range word.
    issue(1'b1, 64'h0, WD, 8'hFF, 64'd0, 1'b0);
    issue(1'b0, 64'h800, 64'd0, 8'h00, 64'd0, 1'b1);
    issue(1'b1, 64'h800, 64'd0, 8'hFF, 64'd0, 1'b1);
    issue(1'b0, 64'h0, 64'd0, 8'h00, WD, 1'b0);
    issue(1'b0, 64'h8000000000000010, 64'd0, 8'h00, 64'd0, 1'b1);
    issue(1'b1, 64'h7F8, WT, 8'hFF, 64'd0, 1'b0);
    issue(1'b0, 64'h7FF, 64'd0, 8'h00, WT, 1'b0);
    wait_done();

    // Backpressure: response held for five cycles.
    resp_ready = 1'b0;
    issue(1'b0, 64'h10, 64'd0, 8'h00, WM, 1'b0);
    begin
      int n = 0;
      @(negedge clk);
      while (!resp_valid && n < 20) begin
        n++;
        @(negedge clk);
      end
      chk("bp_resp_valid", 64'(resp_valid), 64'd1);
      repeat (5) begin
        chk("bp_req_ready", 64'(req_ready), 64'd0);
        chk("bp_acc_cnt", 64'(acc_cnt), 64'(n_exp - 1));
        @(negedge clk);
      end
      drive_point();
      resp_ready = 1'b1;
    end
    wait_done();

    // Reset during BUSY of a load.
    issue(1'b0, 64'h10, 64'd0, 8'h00, WM, 1'b0);
    rst = 1'b1;
    sb.delete();
    n_exp = 0;
    @(negedge clk);
    drive_point();
    @(negedge clk);
    chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
    chk("midrst_acc_cnt", 64'(acc_cnt), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    drive_point();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready_after", 64'(req_ready), 64'd1);
    drive_point();
    issue(1'b0, 64'h10, 64'd0, 8'h00, WM, 1'b0);
    wait_done();

    // LAT=0 instance: request held, response ready tied high.
    f_valid = 1'b1; f_we = 1'b1; f_addr = 64'h40; f_wdata = WF; f_wmask = 8'hFF;
    @(negedge clk);
    chk("f_ready_idle", 64'(f_ready), 64'd1);
    chk("f_valid_idle", 64'(f_resp_valid), 64'd0);
    drive_point();
    f_we = 1'b0;
    @(negedge clk);
    chk("f_store_valid", 64'(f_resp_valid), 64'd1);
    chk("f_store_ready", 64'(f_ready), 64'd0);
    chk("f_store_rdata", f_rdata, 64'd0);
    for (int i = 0; i < 3; i++) begin
      drive_point();
      f_we = 1'b0; f_addr = 64'h40;
      @(negedge clk);
      chk("f_ready_gap", 64'(f_ready), 64'd1);
      chk("f_valid_gap", 64'(f_resp_valid), 64'd0);
      drive_point();
      f_we = 1'b1; f_wdata = 64'd0; f_addr = 64'h40;
      @(negedge clk);
      chk("f_load_valid", 64'(f_resp_valid), 64'd1);
      chk("f_load_ready", 64'(f_ready), 64'd0);
      chk("f_load_rdata", f_rdata, WF);
      chk("f_load_err", 64'(f_err), 64'd0);
    end
    drive_point();
    f_valid = 1'b0;
    @(negedge clk);
    chk("f_acc_cnt", 64'(f_acc_cnt), 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
